truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Upstream stimulus/capture stage for the lab's combinational logic functions.
//  On start, drives every input combination {A,B,C,D} (A = MSB) into a combinational function under test, one vector at a time.
//  Samples that function's Y and records it into a truth-table register.
//  Compares the table against an expected mask and reports the mismatch count plus pass/fail.
//  Lets gate-level and operator-level forms of the same function be checked on one clock.
// PARAMETERS
//  N_IN    4  number of function inputs (2..6); table width = 2**N_IN
//  SETTLE  1  cycles each vector is held before sampling (>=1)
// PORTS
//  clk           in   1          single clock, rising edge
//  rst_n         in   1          asynchronous active-low reset
//  start         in   1          request a sweep; honoured only in IDLE
//  expected      in   2**N_IN    expected truth table, bit i = Y for vector i
//  y_in          in   1          Y from the function under test
//  abcd_out      out  N_IN       vector driven to the function under test
//  busy          out  1          high from the cycle after start until DONE exits
//  done          out  1          one-cycle pulse when the sweep completes
//  table_out     out  2**N_IN    captured truth table
//  mismatch_cnt  out  N_IN+1     number of vectors where y_in != expected
//  pass          out  1          mismatch_cnt==0, valid from done; held
// BEHAVIOUR
//  Reset values (async, rst_n=0): state=IDLE, abcd_out=0, busy=0, done=0, table_out=0, mismatch_cnt=0, pass=0.
//  FSM states: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
//  IDLE, start=1 -> latch expected, clear table_out and mismatch_cnt, clear pass, vec=0, settle_cnt=0, go to DRIVE.
//  DRIVE: abcd_out=vec; settle_cnt increments each cycle; at settle_cnt==SETTLE-1 go to SAMPLE.
//  SAMPLE: abcd_out stays = vec; table_out[vec] <= y_in; if y_in != expected_q[vec], mismatch_cnt++.
//    vec == 2**N_IN-1 -> DONE; otherwise vec++, settle_cnt=0, back to DRIVE.
//  DONE (one cycle): done=1; pass <= (final mismatch_cnt==0); busy=0 on the following cycle; return to IDLE.
//  Latency: start sampled in cycle 0; done high in cycle 1 + 2**N_IN*(SETTLE+1). Defaults give cycle 33.
//  start is ignored in DRIVE, SAMPLE and DONE; it is not queued.
//  expected is latched at start; changes during a sweep have no effect.
//  y_in is sampled only in SAMPLE cycles; the function under test is combinational from abcd_out.
//  After done: table_out, mismatch_cnt, pass and abcd_out (= 2**N_IN-1) hold until the next accepted start.
//  mismatch_cnt range is 0..2**N_IN, so it cannot wrap.
//  vec wraps only by re-entering IDLE.
//  Reset mid-sweep: immediately aborts to the reset values above; no done pulse; the next start runs a full sweep from vec=0.
// STRUCTURE
//  Package sweep_pkg: state enum (IDLE, DRIVE, SAMPLE, DONE); localparam TBL_W = 2**N_IN; CNT_W = N_IN+1.
//  Sub-module sweep_settle_timer: SETTLE-cycle down-counter with load/expire, clk/rst_n.
//  Top holds the FSM, the vec counter, the table register and the compare logic.
// TESTING
//  1 Y=(B&D)|(A&~D)|(A&C), expected=16'hFDA0, start pulse -> done in cycle 33, table_out=16'hFDA0, mismatch_cnt=0, pass=1.
//  2 Y=~B, expected=16'h0F0E -> table_out=16'h0F0F, mismatch_cnt=1, pass=0.
//  3 Start held high during a sweep, and start asserted in the DONE cycle -> exactly one sweep, one done pulse.
//  4 rst_n low while abcd_out=6 -> all outputs 0 asynchronously, no done pulse; new start -> full 16-vector sweep, correct table.
//  5 SETTLE=3: each vector held 4 cycles, y_in sampled only in the 4th; done in cycle 65.
//  6 expected changed mid-sweep from 16'h0F0F to 16'h0000 with Y=~B -> result uses latched 16'h0F0F, pass=1.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM state type and default table geometry for the truth-table sweeper
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int N_IN_DEF = 4;
    localparam int TBL_W    = 2**N_IN_DEF;
    localparam int CNT_W    = N_IN_DEF + 1;
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter that expires after SETTLE drive cycles
module sweep_settle_timer
#(
    parameter int SETTLE = 1
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_expire
);
    localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;
    logic [W-1:0] r_cnt;
    // load SETTLE-1 on each new vector, then count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= W'(SETTLE - 1);
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_expire = r_cnt == '0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector into a combinational function, captures Y and compares to an expected table
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1,
    localparam int L_TBL_W = 2**N_IN,
    localparam int L_CNT_W = N_IN + 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [L_TBL_W-1:0] expected,
    input  logic               y_in,
    output logic [N_IN-1:0]    abcd_out,
    output logic               busy,
    output logic               done,
    output logic [L_TBL_W-1:0] table_out,
    output logic [L_CNT_W-1:0] mismatch_cnt,
    output logic               pass
);
    state_t               r_state, w_next;
    logic [N_IN-1:0]      r_vec;
    logic [L_TBL_W-1:0]   r_exp;
    logic [L_TBL_W-1:0]   r_table;
    logic [L_CNT_W-1:0]   r_cnt;
    logic                 r_pass;
    logic                 w_accept, w_sample, w_last, w_load, w_expire, w_miss;
    logic [L_CNT_W-1:0]   w_cnt_nxt;

    sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .o_expire (w_expire)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next-state and control strobes; start only counts in IDLE
    always_comb begin
        w_accept  = r_state == IDLE && start;
        w_sample  = r_state == SAMPLE;
        w_last    = &r_vec;
        w_load    = w_accept || (w_sample && !w_last);
        w_miss    = y_in != r_exp[r_vec];
        w_cnt_nxt = r_cnt + L_CNT_W'(w_miss);
        w_next    = r_state;
        case (r_state)
            IDLE:    w_next = start ? DRIVE : IDLE;
            DRIVE:   w_next = w_expire ? SAMPLE : DRIVE;
            SAMPLE:  w_next = w_last ? DONE : DRIVE;
            default: w_next = IDLE;
        endcase
    end

    // datapath: latch expected at start, capture y_in and tally misses in SAMPLE;
    // pass is settled on the last sample so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec   <= '0;
            r_exp   <= '0;
            r_table <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
        end else if (w_accept) begin
            r_vec   <= '0;
            r_exp   <= expected;
            r_table <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
        end else if (w_sample) begin
            r_table[r_vec] <= y_in;
            r_cnt          <= w_cnt_nxt;
            if (w_last) r_pass <= w_cnt_nxt == '0;
            else r_vec <= r_vec + 1'b1;
        end
    end

    assign abcd_out     = r_vec;
    assign busy         = r_state != IDLE;
    assign done         = r_state == DONE;
    assign table_out    = r_table;
    assign mismatch_cnt = r_cnt;
    assign pass         = r_pass;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed-vector bench for truth_table_sweeper (SETTLE=1 and SETTLE=3 instances)
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, fsel = 1'b0, y1;
    logic [15:0] expected = '0;
    logic [3:0]  abcd;
    logic        busy, done, pass;
    logic [15:0] tbl;
    logic [4:0]  mcnt;
    logic        start2 = 1'b0, y2 = 1'b0;
    logic [15:0] expected2 = '0;
    logic [3:0]  abcd2;
    logic        busy2, done2, pass2;
    logic [15:0] tbl2;
    logic [4:0]  mcnt2;
    int          n_vec = 0, n_miss = 0;

    always #5 clk = ~clk;

    // function under test for dut: fsel=0 -> (B&D)|(A&~D)|(A&C), fsel=1 -> ~B
    always_comb y1 = fsel ? ~abcd[2] : ((abcd[2] & abcd[0]) | (abcd[3] & ~abcd[0]) | (abcd[3] & abcd[1]));

    truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .y_in(y1),
        .abcd_out(abcd), .busy(busy), .done(done), .table_out(tbl),
        .mismatch_cnt(mcnt), .pass(pass)
    );

    truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .y_in(y2),
        .abcd_out(abcd2), .busy(busy2), .done(done2), .table_out(tbl2),
        .mismatch_cnt(mcnt2), .pass(pass2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input logic [15:0] exp, input bit hold, input int chg,
                         output int lat, output int nd, output logic b1);
        expected = exp;
        start = 1'b1;
        tick();
        lat = -1;
        nd = 0;
        b1 = busy;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == chg) expected = '0;
            if (done === 1'b1) begin
                nd++;
                if (lat < 0) lat = c;
            end
            tick();
            if (lat >= 0) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({abcd, busy, done, tbl, mcnt, pass} !== '0 || {abcd2, busy2, done2, tbl2, mcnt2, pass2} !== '0) begin
            n_miss++;
            $display("FAIL reset: got abcd=%h busy=%b done=%b tbl=%h mcnt=%0d pass=%b, want all zero", abcd, busy, done, tbl, mcnt, pass);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_function();
        int lat, nd;
        logic b1;
        fsel = 1'b0;
        sweep(16'hFDA0, 1'b0, -1, lat, nd, b1);
        n_vec++;
        if (lat !== 33) begin n_miss++; $display("FAIL func_latency: got %0d want 33", lat); end
        n_vec++;
        if (nd !== 1) begin n_miss++; $display("FAIL func_done_count: got %0d want 1", nd); end
        n_vec++;
        if (b1 !== 1'b1) begin n_miss++; $display("FAIL func_busy: got %b want 1", b1); end
        n_vec++;
        if (tbl !== 16'hFDA0) begin n_miss++; $display("FAIL func_table: got %h want fda0", tbl); end
        n_vec++;
        if (mcnt !== 5'd0 || pass !== 1'b1) begin n_miss++; $display("FAIL func_result: got mcnt=%0d pass=%b want 0/1", mcnt, pass); end
        n_vec++;
        if (abcd !== 4'hF || busy !== 1'b0) begin n_miss++; $display("FAIL func_hold: got abcd=%h busy=%b want f/0", abcd, busy); end
    endtask

    task automatic test_mismatch();
        int lat, nd;
        logic b1;
        fsel = 1'b1;
        sweep(16'h0F0E, 1'b0, -1, lat, nd, b1);
        n_vec++;
        if (tbl !== 16'h0F0F) begin n_miss++; $display("FAIL mis_table: got %h want 0f0f", tbl); end
        n_vec++;
        if (mcnt !== 5'd1) begin n_miss++; $display("FAIL mis_count: got %0d want 1", mcnt); end
        n_vec++;
        if (pass !== 1'b0) begin n_miss++; $display("FAIL mis_pass: got %b want 0", pass); end
    endtask

    task automatic test_back_to_back();
        int lat, nd;
        logic b1;
        fsel = 1'b1;
        sweep(16'h0F0F, 1'b1, -1, lat, nd, b1);
        n_vec++;
        if (nd !== 1 || lat !== 33) begin n_miss++; $display("FAIL held_start: got done_count=%0d latency=%0d want 1/33", nd, lat); end
        n_vec++;
        if (busy !== 1'b0 || pass !== 1'b1) begin n_miss++; $display("FAIL held_start_end: got busy=%b pass=%b want 0/1", busy, pass); end
    endtask

    task automatic test_reset_mid();
        int k = 0, nd = 0, lat;
        logic b1;
        fsel = 1'b0;
        expected = 16'hFDA0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (abcd !== 4'd6 && k < 40) begin tick(); k++; end
        n_vec++;
        if (k >= 40) begin n_miss++; $display("FAIL midreset_reach: got abcd=%h want 6 within 40 cycles", abcd); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({abcd, busy, done, tbl, mcnt, pass} !== '0) begin
            n_miss++;
            $display("FAIL midreset_async: got abcd=%h busy=%b done=%b tbl=%h mcnt=%0d pass=%b want zero", abcd, busy, done, tbl, mcnt, pass);
        end
        for (int c = 0; c < 45; c++) begin
            if (c == 5) rst_n = 1'b1;
            if (done === 1'b1) nd++;
            tick();
        end
        n_vec++;
        if (nd !== 0) begin n_miss++; $display("FAIL midreset_nodone: got %0d done pulses want 0", nd); end
        sweep(16'hFDA0, 1'b0, -1, lat, nd, b1);
        n_vec++;
        if (lat !== 33 || tbl !== 16'hFDA0 || mcnt !== 5'd0 || pass !== 1'b1) begin
            n_miss++;
            $display("FAIL midreset_rerun: got lat=%0d tbl=%h mcnt=%0d pass=%b want 33/fda0/0/1", lat, tbl, mcnt, pass);
        end
    endtask

    task automatic test_settle3();
        int lat = -1;
        bit ok = 1'b1;
        expected2 = 16'h0F0F;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            if (c <= 64) begin
                if (abcd2 !== 4'((c - 1) / 4)) ok = 1'b0;
                y2 = ((c - 1) % 4 == 3) ? ~abcd2[2] : abcd2[2];
            end else y2 = 1'b0;
            if (done2 === 1'b1 && lat < 0) lat = c;
            tick();
        end
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL settle3_hold: got a vector not held for 4 cycles, want 4-cycle hold"); end
        n_vec++;
        if (lat !== 65) begin n_miss++; $display("FAIL settle3_latency: got %0d want 65", lat); end
        n_vec++;
        if (tbl2 !== 16'h0F0F || mcnt2 !== 5'd0 || pass2 !== 1'b1) begin
            n_miss++;
            $display("FAIL settle3_result: got tbl=%h mcnt=%0d pass=%b want 0f0f/0/1", tbl2, mcnt2, pass2);
        end
    endtask

    task automatic test_latch();
        int lat, nd;
        logic b1;
        fsel = 1'b1;
        sweep(16'h0F0F, 1'b0, 10, lat, nd, b1);
        n_vec++;
        if (tbl !== 16'h0F0F || mcnt !== 5'd0 || pass !== 1'b1) begin
            n_miss++;
            $display("FAIL latch_expected: got tbl=%h mcnt=%0d pass=%b want 0f0f/0/1", tbl, mcnt, pass);
        end
    endtask

    initial begin
        test_reset();
        test_function();
        test_mismatch();
        test_back_to_back();
        test_reset_mid();
        test_settle3();
        test_latch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
